queue: RTL and testbench

Synchronous first-in first-out buffer, the complement of the LIFO `Stack` in the processor memory library. It shares the stack's `push`/`pop`/`data_IN`/`data_OUT` port shape, so the two are drop-in alternatives wherever operand or instruction buffering is needed. Entries leave in arrival order. Full, empty, occupancy and sticky error flags let producer and consumer logic throttle without external bookkeeping.

---
 rtl/queue.sv | 125 ++++++++++++
 tb/tb_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/queue.sv
`default_nettype none
// ============================================================================
// Module   : queue
// Brief    : Synchronous FIFO with first-word fall-through output, occupancy
//            count, full/empty status and sticky overflow/underflow flags.
//            Port shape matches the LIFO stack so the two are interchangeable.
// Revision : 1.0 - initial release
// ============================================================================
module queue #(
   parameter int   length     = 8,
   parameter int   data_width = 8,
   localparam int  cnt_width  = $clog2(length + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [data_width-1:0] data_IN,
   output logic [data_width-1:0] data_OUT,
   output logic                  full,
   output logic                  empty,
   output logic [cnt_width-1:0]  count,
   output logic                  overflow,
   output logic                  underflow
);

   // Pointers only need to address 0..length-1; length >= 2 keeps this >= 1.
   localparam int c_PTR_WIDTH = $clog2(length);

   logic [data_width-1:0]  r_mem [length];
   logic [c_PTR_WIDTH-1:0] r_head;
   logic [c_PTR_WIDTH-1:0] r_tail;
   logic [cnt_width-1:0]   r_count;
   logic                   r_overflow;
   logic                   r_underflow;

   logic w_full;
   logic w_empty;
   logic w_do_pop;
   logic w_do_push;

   // Pointer increment that wraps at length-1, so non-power-of-two depths work.
   function automatic logic [c_PTR_WIDTH-1:0] f_next_ptr(input logic [c_PTR_WIDTH-1:0] ptr);
      logic [c_PTR_WIDTH-1:0] nxt;
      if (ptr == c_PTR_WIDTH'(length - 1)) begin
         nxt = '0;
      end else begin
         nxt = ptr + 1'b1;
      end
      return nxt;
   endfunction

   // Status and effective operations; a push into a full queue is allowed
   // only when a pop frees the head slot in the same cycle.
   always_comb begin
      w_full    = (r_count == cnt_width'(length));
      w_empty   = (r_count == '0);
      w_do_pop  = pop & ~w_empty;
      w_do_push = push & (~w_full | w_do_pop);
   end

   // Storage write at the tail; contents are deliberately not cleared by reset,
   // but a push coinciding with reset is never committed.
   always_ff @(posedge clk) begin
      if (!rst && w_do_push) begin
         r_mem[r_tail] <= data_IN;
      end
   end

   // Head/tail pointers advance on their effective operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_do_pop) begin
            r_head <= f_next_ptr(r_head);
         end
         if (w_do_push) begin
            r_tail <= f_next_ptr(r_tail);
         end
      end
   end

   // Occupancy counter: simultaneous push and pop cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (push && !w_do_push) begin
            r_overflow <= 1'b1;
         end
         if (pop && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // Outputs derive from registered state only; empty forces zero so the
   // head never exposes stale storage.
   always_comb begin
      data_OUT  = w_empty ? '0 : r_mem[r_head];
      full      = w_full;
      empty     = w_empty;
      count     = r_count;
      overflow  = r_overflow;
      underflow = r_underflow;
   end

endmodule
`default_nettype wire

// File: tb/tb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue
// Brief    : Directed scoreboard bench for queue at depth 8 and depth 5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;

   logic       push8, pop8;
   logic [7:0] din8, dout8;
   logic       full8, empty8, ovf8, unf8;
   logic [3:0] cnt8;

   logic       push5, pop5;
   logic [7:0] din5, dout5;
   logic       full5, empty5, ovf5, unf5;
   logic [2:0] cnt5;

   int checks = 0;
   int fails  = 0;

   logic [7:0] exp8[$];
   logic [7:0] exp5[$];

   queue #(.length(8), .data_width(8)) dut8 (
      .clk(clk), .rst(rst), .push(push8), .pop(pop8), .data_IN(din8),
      .data_OUT(dout8), .full(full8), .empty(empty8), .count(cnt8),
      .overflow(ovf8), .underflow(unf8)
   );

   queue #(.length(5), .data_width(8)) dut5 (
      .clk(clk), .rst(rst), .push(push5), .pop(pop5), .data_IN(din5),
      .data_OUT(dout5), .full(full5), .empty(empty5), .count(cnt5),
      .overflow(ovf5), .underflow(unf5)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: whenever a DUT is about to pop a non-empty queue, the head it
   // presents must be the oldest expected entry.
   always @(negedge clk) begin
      if (!rst) begin
         if (pop8 && !empty8) begin
            if (exp8.size() == 0) check("q8_unexpected_out", {24'd0, dout8}, 32'hFFFF_FFFF);
            else                  check("q8_data_out", {24'd0, dout8}, {24'd0, exp8.pop_front()});
         end
         if (pop5 && !empty5) begin
            if (exp5.size() == 0) check("q5_unexpected_out", {24'd0, dout5}, 32'hFFFF_FFFF);
            else                  check("q5_data_out", {24'd0, dout5}, {24'd0, exp5.pop_front()});
         end
      end
   end

   task automatic op8(input logic p, input logic q, input logic [7:0] d);
      push8 = p; pop8 = q; din8 = d;
      @(posedge clk); #1;
      push8 = 1'b0; pop8 = 1'b0;
   endtask

   task automatic op5(input logic p, input logic q, input logic [7:0] d);
      push5 = p; pop5 = q; din5 = d;
      @(posedge clk); #1;
      push5 = 1'b0; pop5 = 1'b0;
   endtask

   task automatic reset_all();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      push8 = 0; pop8 = 0; din8 = 0;
      push5 = 0; pop5 = 0; din5 = 0;
      reset_all();

      // Reset state
      check("rst_empty", empty8, 1);
      check("rst_full",  full8, 0);
      check("rst_count", cnt8, 0);
      check("rst_dout",  dout8, 0);
      check("rst_ovf",   ovf8, 0);
      check("rst_unf",   unf8, 0);

      // Basic ordering 0x11, 0x22, 0x33
      exp8.push_back(8'h11); exp8.push_back(8'h22); exp8.push_back(8'h33);
      op8(1, 0, 8'h11); check("t1_cnt1", cnt8, 1); check("t1_fwft", dout8, 8'h11);
      op8(1, 0, 8'h22); check("t1_cnt2", cnt8, 2);
      op8(1, 0, 8'h33); check("t1_cnt3", cnt8, 3);
      op8(0, 1, 8'h00); check("t1_cnt4", cnt8, 2);
      op8(0, 1, 8'h00); check("t1_cnt5", cnt8, 1);
      op8(0, 1, 8'h00); check("t1_cnt6", cnt8, 0);
      check("t1_empty", empty8, 1);
      check("t1_ovf", ovf8, 0);
      check("t1_unf", unf8, 0);
      check("t1_sb_drained", exp8.size(), 0);

      // Fill to 8 then push 0xAA which must be dropped
      for (int i = 0; i < 8; i++) begin
         exp8.push_back(8'(i));
         op8(1, 0, 8'(i));
      end
      check("t2_cnt_full", cnt8, 8);
      check("t2_full", full8, 1);
      op8(1, 0, 8'hAA);
      check("t2_cnt_after_drop", cnt8, 8);
      check("t2_ovf", ovf8, 1);
      check("t2_full_after", full8, 1);
      for (int i = 0; i < 8; i++) op8(0, 1, 8'h00);
      check("t2_empty", empty8, 1);
      check("t2_sb_drained", exp8.size(), 0);

      // Full with simultaneous push/pop: new entry takes freed slot
      reset_all();
      for (int i = 0; i < 8; i++) begin
         exp8.push_back(8'(i));
         op8(1, 0, 8'(i));
      end
      exp8.push_back(8'hBB);
      op8(1, 1, 8'hBB);
      check("t3_cnt", cnt8, 8);
      check("t3_full", full8, 1);
      check("t3_ovf", ovf8, 0);
      check("t3_head", dout8, 8'h01);
      for (int i = 0; i < 8; i++) op8(0, 1, 8'h00);
      check("t3_empty", empty8, 1);
      check("t3_sb_drained", exp8.size(), 0);

      // Wrap-around with occupancy held at 3
      reset_all();
      for (int i = 1; i <= 3; i++) begin
         exp8.push_back(8'(i));
         op8(1, 0, 8'(i));
      end
      for (int k = 4; k <= 23; k++) begin
         exp8.push_back(8'(k));
         op8(1, 1, 8'(k));
         check("t4_cnt_held", cnt8, 3);
      end
      check("t4_head_after_stream", dout8, 8'd21);
      for (int i = 0; i < 3; i++) op8(0, 1, 8'h00);
      check("t4_empty", empty8, 1);
      check("t4_sb_drained", exp8.size(), 0);
      check("t4_flags", {ovf8, unf8}, 0);

      // Push and pop on empty: push happens, pop flagged
      op8(1, 1, 8'h5C);
      check("t5_unf", unf8, 1);
      check("t5_cnt", cnt8, 1);
      check("t5_dout", dout8, 8'h5C);
      check("t5_empty", empty8, 0);
      // Reset wins over a simultaneous push
      rst = 1'b1;
      op8(1, 0, 8'h77);
      rst = 1'b0;
      check("t5_rst_cnt", cnt8, 0);
      check("t5_rst_empty", empty8, 1);
      check("t5_rst_dout", dout8, 0);
      check("t5_rst_ovf", ovf8, 0);
      check("t5_rst_unf", unf8, 0);
      op8(0, 0, 8'h00);
      check("t5_push_not_stored", cnt8, 0);

      // Non-power-of-two depth 5: values 6 and 7 dropped
      for (int i = 1; i <= 7; i++) begin
         if (i <= 5) exp5.push_back(8'(i));
         op5(1, 0, 8'(i));
      end
      check("t6_cnt", cnt5, 5);
      check("t6_full", full5, 1);
      check("t6_ovf", ovf5, 1);
      for (int i = 0; i < 5; i++) begin
         op5(0, 1, 8'h00);
         check("t6_unf_clear", unf5, 0);
      end
      check("t6_empty", empty5, 1);
      check("t6_cnt0", cnt5, 0);
      check("t6_sb_drained", exp5.size(), 0);
      op5(0, 1, 8'h00);
      check("t6_unf_set", unf5, 1);
      check("t6_cnt_still0", cnt5, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
